// File: rtl/execute_stage.sv
// EX stage of the RV32I pipeline: operand forwarding, ALU, branch/jump redirect,
// and the EX/MEM pipeline register feeding the MEM stage and the forwarding unit.
module execute_stage #(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [XLEN-1:0] RD1E,
   input  logic [XLEN-1:0] RD2E,
   input  logic [XLEN-1:0] ImmExtE,
   input  logic [XLEN-1:0] PCE,
   input  logic [XLEN-1:0] PCPlus4E,
   input  logic [4:0]      RdE,
   input  logic            RegWriteE,
   input  logic            MemWriteE,
   input  logic            ResultSrcE,
   input  logic            ALUSrcE,
   input  logic            BranchE,
   input  logic            JumpE,
   input  logic [2:0]      ALUControlE,
   input  logic [1:0]      ForwardAE,
   input  logic [1:0]      ForwardBE,
   input  logic [XLEN-1:0] ResultW,
   output logic            PCSrcE,
   output logic [XLEN-1:0] PCTargetE,
   output logic [XLEN-1:0] ALUResultM,
   output logic [XLEN-1:0] WriteDataM,
   output logic [XLEN-1:0] PCPlus4M,
   output logic [4:0]      RdM,
   output logic            RegWriteM,
   output logic            MemWriteM,
   output logic            ResultSrcM
);

   logic [XLEN-1:0] src_a, fwd_b, src_b, alu_result;
   logic            zero;

   logic [XLEN-1:0] alu_result_d, alu_result_q;
   logic [XLEN-1:0] write_data_d, write_data_q;
   logic [XLEN-1:0] pc_plus4_d, pc_plus4_q;
   logic [4:0]      rd_d, rd_q;
   logic            reg_write_d, reg_write_q;
   logic            mem_write_d, mem_write_q;
   logic            result_src_d, result_src_q;

   // Select 10 feeds back this stage's own registered result (immediately older instruction).
   always_comb begin
      src_a = RD1E;
      case (ForwardAE)
         2'b01:   src_a = ResultW;
         2'b10:   src_a = alu_result_q;
         default: src_a = RD1E;
      endcase
      fwd_b = RD2E;
      case (ForwardBE)
         2'b01:   fwd_b = ResultW;
         2'b10:   fwd_b = alu_result_q;
         default: fwd_b = RD2E;
      endcase
      src_b = ALUSrcE ? ImmExtE : fwd_b;
   end

   always_comb begin
      alu_result = '0;
      case (ALUControlE)
         3'b000:  alu_result = src_a + src_b;
         3'b001:  alu_result = src_a - src_b;
         3'b010:  alu_result = src_a & src_b;
         3'b011:  alu_result = src_a | src_b;
         3'b100:  alu_result = src_a ^ src_b;
         3'b101:  alu_result = {{(XLEN-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
         3'b110:  alu_result = src_a << src_b[4:0];
         default: alu_result = '0;
      endcase
      zero = (alu_result == '0);
   end

   assign PCTargetE = PCE + ImmExtE;
   assign PCSrcE    = JumpE | (BranchE & zero);

   always_comb begin
      alu_result_d = alu_result;
      write_data_d = fwd_b;
      pc_plus4_d   = PCPlus4E;
      rd_d         = RdE;
      reg_write_d  = RegWriteE;
      mem_write_d  = MemWriteE;
      result_src_d = ResultSrcE;
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         alu_result_q <= '0;
         write_data_q <= '0;
         pc_plus4_q   <= '0;
         rd_q         <= '0;
         reg_write_q  <= 1'b0;
         mem_write_q  <= 1'b0;
         result_src_q <= 1'b0;
      end else begin
         alu_result_q <= alu_result_d;
         write_data_q <= write_data_d;
         pc_plus4_q   <= pc_plus4_d;
         rd_q         <= rd_d;
         reg_write_q  <= reg_write_d;
         mem_write_q  <= mem_write_d;
         result_src_q <= result_src_d;
      end
   end

   assign ALUResultM = alu_result_q;
   assign WriteDataM = write_data_q;
   assign PCPlus4M   = pc_plus4_q;
   assign RdM        = rd_q;
   assign RegWriteM  = reg_write_q;
   assign MemWriteM  = mem_write_q;
   assign ResultSrcM = result_src_q;

endmodule

// File: tb/tb_execute_stage.sv
// Bench for execute_stage: directed literal checks plus randomized traffic
// compared every cycle against a behavioural EX/MEM model.
module tb_execute_stage;

   logic        clk, rst;
   logic [31:0] RD1E, RD2E, ImmExtE, PCE, PCPlus4E, ResultW;
   logic [4:0]  RdE;
   logic        RegWriteE, MemWriteE, ResultSrcE, ALUSrcE, BranchE, JumpE;
   logic [2:0]  ALUControlE;
   logic [1:0]  ForwardAE, ForwardBE;
   logic        PCSrcE;
   logic [31:0] PCTargetE, ALUResultM, WriteDataM, PCPlus4M;
   logic [4:0]  RdM;
   logic        RegWriteM, MemWriteM, ResultSrcM;

   int total = 0;
   int bad   = 0;

   execute_stage #(.XLEN(32)) dut (
      .clk(clk), .rst(rst), .RD1E(RD1E), .RD2E(RD2E), .ImmExtE(ImmExtE),
      .PCE(PCE), .PCPlus4E(PCPlus4E), .RdE(RdE), .RegWriteE(RegWriteE),
      .MemWriteE(MemWriteE), .ResultSrcE(ResultSrcE), .ALUSrcE(ALUSrcE),
      .BranchE(BranchE), .JumpE(JumpE), .ALUControlE(ALUControlE),
      .ForwardAE(ForwardAE), .ForwardBE(ForwardBE), .ResultW(ResultW),
      .PCSrcE(PCSrcE), .PCTargetE(PCTargetE), .ALUResultM(ALUResultM),
      .WriteDataM(WriteDataM), .PCPlus4M(PCPlus4M), .RdM(RdM),
      .RegWriteM(RegWriteM), .MemWriteM(MemWriteM), .ResultSrcM(ResultSrcM)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   logic [31:0] m_alu, m_wd, m_pc4;
   logic [4:0]  m_rd;
   logic        m_rw, m_mw, m_rs;
   bit          model_valid = 0;

   function automatic logic [31:0] pick(input logic [1:0] sel, input logic [31:0] rf,
                                        input logic [31:0] w, input logic [31:0] m);
      if (sel == 2'd1) return w;
      if (sel == 2'd2) return m;
      return rf;
   endfunction

   function automatic logic [31:0] alu(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      case (op)
         3'd0: return a + b;
         3'd1: return a - b;
         3'd2: return a & b;
         3'd3: return a | b;
         3'd4: return a ^ b;
         3'd5: return (int'(a) < int'(b)) ? 32'd1 : 32'd0;
         3'd6: return a << (b % 32);
         default: return 32'd0;
      endcase
   endfunction

   function automatic logic [31:0] model_result();
      logic [31:0] a, b;
      a = pick(ForwardAE, RD1E, ResultW, m_alu);
      b = ALUSrcE ? ImmExtE : pick(ForwardBE, RD2E, ResultW, m_alu);
      return alu(ALUControlE, a, b);
   endfunction

   always @(posedge clk) begin
      if (!rst) begin
         m_alu = 0; m_wd = 0; m_pc4 = 0; m_rd = 0; m_rw = 0; m_mw = 0; m_rs = 0;
         model_valid = 1;
      end else begin
         logic [31:0] r, wd;
         r  = model_result();
         wd = pick(ForwardBE, RD2E, ResultW, m_alu);
         m_alu = r; m_wd = wd; m_pc4 = PCPlus4E; m_rd = RdE;
         m_rw = RegWriteE; m_mw = MemWriteE; m_rs = ResultSrcE;
      end
   end

   always @(negedge clk) begin
      if (model_valid) begin
         logic [31:0] r;
         r = model_result();
         check("PCTargetE",  PCTargetE, PCE + ImmExtE);
         check("PCSrcE",     {31'd0, PCSrcE}, {31'd0, JumpE | (BranchE & (r == 0))});
         check("ALUResultM", ALUResultM, m_alu);
         check("WriteDataM", WriteDataM, m_wd);
         check("PCPlus4M",   PCPlus4M, m_pc4);
         check("RdM",        {27'd0, RdM}, {27'd0, m_rd});
         check("RegWriteM",  {31'd0, RegWriteM}, {31'd0, m_rw});
         check("MemWriteM",  {31'd0, MemWriteM}, {31'd0, m_mw});
         check("ResultSrcM", {31'd0, ResultSrcM}, {31'd0, m_rs});
      end
   end

   // ---------------- stimulus ----------------
   task automatic clear_inputs();
      RD1E = 0; RD2E = 0; ImmExtE = 0; PCE = 0; PCPlus4E = 0; ResultW = 0; RdE = 0;
      RegWriteE = 0; MemWriteE = 0; ResultSrcE = 0; ALUSrcE = 0; BranchE = 0; JumpE = 0;
      ALUControlE = 0; ForwardAE = 0; ForwardBE = 0;
   endtask

   task automatic cyc();
      @(posedge clk);
      #2;
   endtask

   initial begin
      rst = 1'b0;
      clear_inputs();
      RD1E = 5; RD2E = 7; ImmExtE = 3; PCE = 32'h40; PCPlus4E = 32'h44; RdE = 5'd9;
      ResultW = 32'h1234; RegWriteE = 1; MemWriteE = 1; ResultSrcE = 1;
      #2;
      repeat (2) cyc();
      check("rst_alu",  ALUResultM, 0);
      check("rst_wd",   WriteDataM, 0);
      check("rst_pc4",  PCPlus4M, 0);
      check("rst_rd",   {27'd0, RdM}, 0);
      check("rst_rw",   {31'd0, RegWriteM}, 0);
      check("rst_mw",   {31'd0, MemWriteM}, 0);
      check("rst_rs",   {31'd0, ResultSrcM}, 0);

      clear_inputs();
      rst = 1'b1; RD1E = 5; RD2E = 7;
      cyc();
      check("first_add", ALUResultM, 32'd12);

      RD1E = 32'h8; RD2E = 32'h8;
      cyc();
      check("m_fwd_src", ALUResultM, 32'h10);
      RD1E = 0; ForwardAE = 2'b10; ALUSrcE = 1; ImmExtE = 4;
      cyc();
      check("m_fwd", ALUResultM, 32'h14);

      clear_inputs();
      ForwardBE = 2'b01; ResultW = 32'hDEADBEEF; ALUSrcE = 1; MemWriteE = 1; RD2E = 32'h55;
      cyc();
      check("w_fwd_store", WriteDataM, 32'hDEADBEEF);
      check("w_fwd_memw", {31'd0, MemWriteM}, 1);

      clear_inputs();
      BranchE = 1; ALUControlE = 3'd1; RD1E = 9; RD2E = 9; PCE = 32'h100; ImmExtE = 32'hFFFFFFF8;
      #1;
      check("beq_taken", {31'd0, PCSrcE}, 1);
      check("beq_target", PCTargetE, 32'hF8);
      RD2E = 8;
      #1;
      check("beq_not_taken", {31'd0, PCSrcE}, 0);

      clear_inputs();
      ALUControlE = 3'd5; RD1E = 32'h80000000; RD2E = 1;
      cyc();
      check("slt_signed", ALUResultM, 1);
      ALUControlE = 3'd0; RD1E = 32'hFFFFFFFF; RD2E = 1;
      cyc();
      check("add_wrap", ALUResultM, 0);
      ALUControlE = 3'd6; RD1E = 1; ALUSrcE = 1; ImmExtE = 33;
      cyc();
      check("sll_mask", ALUResultM, 2);

      clear_inputs();
      JumpE = 1; RegWriteE = 1; RdE = 5'd5; PCPlus4E = 32'h104;
      cyc();
      check("pre_reset_rw", {31'd0, RegWriteM}, 1);
      rst = 1'b0;
      #1;
      check("jump_in_reset", {31'd0, PCSrcE}, 1);
      cyc();
      check("midrst_rw",  {31'd0, RegWriteM}, 0);
      check("midrst_rd",  {27'd0, RdM}, 0);
      check("midrst_pc4", PCPlus4M, 0);
      rst = 1'b1;

      for (int i = 0; i < 3000; i++) begin
         RD1E = $urandom;
         RD2E = ($urandom_range(0, 3) == 0) ? RD1E : $urandom;
         ImmExtE = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 63)) : $urandom;
         PCE = $urandom; PCPlus4E = $urandom; ResultW = $urandom;
         RdE = 5'($urandom); RegWriteE = 1'($urandom); MemWriteE = 1'($urandom);
         ResultSrcE = 1'($urandom); ALUSrcE = 1'($urandom); BranchE = 1'($urandom);
         JumpE = ($urandom_range(0, 7) == 0); ALUControlE = 3'($urandom);
         ForwardAE = 2'($urandom); ForwardBE = 2'($urandom);
         rst = ($urandom_range(0, 31) != 0);
         cyc();
      end

      @(negedge clk);
      #1;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
